// File: rtl/uart_rx_os.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_os                                                   |
// | Description : Oversampling UART receiver. 8N1 framing (DATALEN data bits,  |
// |               LSB first, one start bit, one stop bit, no parity), clocked  |
// |               by a shared OSR x baud tick. Synchronizes the async rx pin,  |
// |               finds the start edge and samples each bit at mid-bit.        |
// |               Good bytes are reported with a one-cycle rx_done strobe;     |
// |               a low stop bit gives a one-cycle frame_err strobe instead.   |
// | Ports       : clk       - system clock                                     |
// |               rst_n     - asynchronous active-low reset                    |
// |               b_tick    - one-clk pulse at OSR x baud rate                 |
// |               rx        - serial input, asynchronous, idle high            |
// |               rx_data   - last correctly framed byte                       |
// |               rx_done   - strobe when rx_data updates                      |
// |               frame_err - strobe when the stop bit samples low             |
// |               busy      - receiver is inside a frame                       |
// | Options     : define UART_RX_MAJORITY_EN for a 3-sample majority vote per  |
// |               bit (decision moves one tick later, at cnt == OSR/2).        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_os #(
    parameter int OSR     = 16,
    parameter int DATALEN = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               b_tick,
    input  logic               rx,
    output logic [DATALEN-1:0] rx_data,
    output logic               rx_done,
    output logic               frame_err,
    output logic               busy
);

    localparam int c_CNT_W = $clog2(OSR);
    localparam int c_IDX_W = (DATALEN > 1) ? $clog2(DATALEN) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OSR - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [c_CNT_W-1:0] c_CNT_DEC  = c_CNT_W'(OSR / 2);
    localparam logic [c_CNT_W-1:0] c_CNT_S0   = c_CNT_W'(OSR / 2 - 2);
    localparam logic [c_CNT_W-1:0] c_CNT_S1   = c_CNT_W'(OSR / 2 - 1);
`else
    localparam logic [c_CNT_W-1:0] c_CNT_DEC  = c_CNT_W'(OSR / 2 - 1);
`endif
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATALEN - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic               r_rx_d;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [DATALEN-1:0] r_shift;
    logic [DATALEN-1:0] r_rx_data;
    logic               r_rx_done;
    logic               r_frame_err;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [DATALEN-1:0] w_shift_nxt;
    logic [DATALEN-1:0] w_data_nxt;
    logic               w_done_nxt;
    logic               w_ferr_nxt;

    logic               w_fall;
    logic               w_tick;
    logic               w_dec;
    logic               w_last;
    logic               w_sample;

    // Two-flop synchronizer plus one delay flop for edge detection. All reset
    // to the idle level so a line held low through reset reads as a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    assign w_fall = r_rx_d & ~r_rx_s;
    // Ticks only count while a frame is in progress.
    assign w_tick = b_tick && (r_state != c_ST_IDLE);
    assign w_dec  = w_tick && (r_cnt == c_CNT_DEC);
    assign w_last = w_tick && (r_cnt == c_CNT_LAST);

`ifdef UART_RX_MAJORITY_EN
    logic r_maj0;
    logic r_maj1;

    // Capture the two samples preceding the decision tick; the third vote is
    // the live synchronized value at the decision tick itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_maj0 <= 1'b1;
            r_maj1 <= 1'b1;
        end else if (w_tick) begin
            if (r_cnt == c_CNT_S0) r_maj0 <= r_rx_s;
            if (r_cnt == c_CNT_S1) r_maj1 <= r_rx_s;
        end
    end

    assign w_sample = (r_maj0 & r_maj1) | (r_maj0 & r_rx_s) | (r_maj1 & r_rx_s);
`else
    assign w_sample = r_rx_s;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_rx_data   <= '0;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_rx_data   <= w_data_nxt;
            r_rx_done   <= w_done_nxt;
            r_frame_err <= w_ferr_nxt;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_rx_data;
        w_done_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;

        // The tick is evaluated at the current count, then the count advances.
        if (w_tick) begin
            w_cnt_nxt = (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CNT_W'(1);
        end

        case (r_state)
            c_ST_IDLE: begin
                if (w_fall) begin
                    w_state_nxt = c_ST_START;
                    w_cnt_nxt   = '0;
                end
            end
            c_ST_START: begin
                // A high sample at mid start bit means a glitch, not a frame.
                if (w_dec && w_sample) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_last) begin
                    w_state_nxt = c_ST_DATA;
                    w_idx_nxt   = '0;
                end
            end
            c_ST_DATA: begin
                // Shift right from the MSB end so the first bit lands in bit 0.
                if (w_dec) begin
                    w_shift_nxt = {w_sample, r_shift[DATALEN-1:1]};
                end
                if (w_last) begin
                    if (r_idx == c_IDX_LAST) begin
                        w_state_nxt = c_ST_STOP;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
            end
            c_ST_STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is caught.
                if (w_dec) begin
                    w_state_nxt = c_ST_IDLE;
                    if (w_sample) begin
                        w_data_nxt = r_shift;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_ferr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign rx_data   = r_rx_data;
    assign rx_done   = r_rx_done;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_os                                                |
// | Description : Self-checking bench for uart_rx_os. Drives serial frames in  |
// |               units of b_tick and compares every strobe against a queue    |
// |               of expected frame outcomes.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_os;

    localparam int OSR     = 16;
    localparam int DATALEN = 8;

    logic               clk;
    logic               rst_n;
    logic               b_tick;
    logic               rx;
    logic [DATALEN-1:0] rx_data;
    logic               rx_done;
    logic               frame_err;
    logic               busy;

    uart_rx_os #(
        .OSR     (OSR),
        .DATALEN (DATALEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .b_tick    (b_tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;

    exp_t       r_exp_q[$];
    exp_t       r_exp;
    logic [7:0] r_last_good;
    int         n_checks;
    int         n_errors;
    int         n_strobes;
    bit         r_prev_strobe;
    int         r_div;
    int         r_tcnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud tick generator: one pulse every r_div clocks (r_div == 1 holds it high).
    initial begin
        b_tick = 1'b0;
        r_tcnt = 0;
        forever begin
            @(negedge clk);
            if (r_tcnt >= r_div - 1) begin
                r_tcnt = 0;
                b_tick = 1'b1;
            end else begin
                r_tcnt = r_tcnt + 1;
                b_tick = 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Strobe monitor: every strobe consumes one expected frame outcome.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_done || frame_err) begin
                n_strobes = n_strobes + 1;
                check_eq("strobe_exclusive", 32'(rx_done & frame_err), 32'd0);
                check_eq("strobe_width", 32'(r_prev_strobe), 32'd0);
                check_eq("busy_at_strobe", 32'(busy), 32'd0);
                if (r_exp_q.size() == 0) begin
                    check_eq("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    r_exp = r_exp_q.pop_front();
                    check_eq("strobe_kind", 32'(frame_err), 32'(r_exp.err));
                    if (!r_exp.err) r_last_good = r_exp.data;
                    check_eq("rx_data", 32'(rx_data), 32'(r_last_good));
                end
            end
            r_prev_strobe = rx_done | frame_err;
        end
    end

    // Wait for n tick pulses, then step just past the edge that sampled the last one.
    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (b_tick) k = k + 1;
        end
        #1;
    endtask

    // One frame: start bit, DATALEN data bits LSB first, stop bit of level stop_val,
    // then gap ticks of idle. glitch_bit >= 0 puts a one-tick high pulse at the
    // mid-bit sample point of that data bit (caller uses it only on 0 bits).
    task automatic send_frame(input logic [7:0] d, input bit stop_val,
                              input int glitch_bit, input int gap);
        logic [7:0] exp_d;
        exp_t       e;
        exp_d = d;
`ifndef UART_RX_MAJORITY_EN
        if (glitch_bit >= 0) exp_d[glitch_bit] = 1'b1;
`endif
        e.err  = !stop_val;
        e.data = exp_d;
        r_exp_q.push_back(e);

        rx = 1'b0;
        wait_ticks(OSR);
        check_eq("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < DATALEN; i++) begin
            rx = d[i];
            if (i == glitch_bit) begin
                wait_ticks(OSR / 2 - 1);
                rx = 1'b1;
                wait_ticks(1);
                rx = d[i];
                wait_ticks(OSR / 2);
            end else begin
                wait_ticks(OSR);
            end
        end
        rx = stop_val;
        wait_ticks(OSR);
        rx = 1'b1;
        if (gap > 0) wait_ticks(gap);
    endtask

    initial begin
        int         n_before;
        int         budget;
        logic [7:0] rd;
        bit         rstop;
        int         rgap;
        logic [7:0] abort_byte;

        n_checks      = 0;
        n_errors      = 0;
        n_strobes     = 0;
        r_prev_strobe = 1'b0;
        r_last_good   = 8'h00;
        r_div         = 4;
        rx            = 1'b1;
        rst_n         = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset_rx_data", 32'(rx_data), 32'd0);
        check_eq("reset_rx_done", 32'(rx_done), 32'd0);
        check_eq("reset_frame_err", 32'(frame_err), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        wait_ticks(4);

        // 0x55 with a tick every 4 clocks.
        n_before = n_strobes;
        send_frame(8'h55, 1'b1, -1, 4);
        check_eq("count_55", 32'(n_strobes - n_before), 32'd1);
        check_eq("data_55", 32'(rx_data), 32'h55);

        // False start: low for 4 ticks only.
        n_before = n_strobes;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(3 * OSR);
        check_eq("false_start_strobes", 32'(n_strobes - n_before), 32'd0);
        check_eq("false_start_busy", 32'(busy), 32'd0);
        check_eq("false_start_data", 32'(rx_data), 32'h55);

        // Good 0x3C, then 0xA3 with a low stop bit.
        send_frame(8'h3C, 1'b1, -1, 2);
        n_before = n_strobes;
        send_frame(8'hA3, 1'b0, -1, 4);
        check_eq("ferr_count", 32'(n_strobes - n_before), 32'd1);
        check_eq("ferr_keeps_data", 32'(rx_data), 32'h3C);

        // Back-to-back 0x00 then 0xFF, no idle between frames.
        n_before = n_strobes;
        send_frame(8'h00, 1'b1, -1, 0);
        send_frame(8'hFF, 1'b1, -1, 4);
        check_eq("b2b_count", 32'(n_strobes - n_before), 32'd2);
        check_eq("b2b_last", 32'(rx_data), 32'hFF);

        // Reset during data bit 4 of a frame.
        abort_byte = 8'hC6;
        n_before = n_strobes;
        rx = 1'b0;
        wait_ticks(OSR);
        for (int i = 0; i < 4; i++) begin
            rx = abort_byte[i];
            wait_ticks(OSR);
        end
        rx = abort_byte[4];
        wait_ticks(OSR / 2);
        rst_n = 1'b0;
        #2;
        check_eq("midreset_rx_data", 32'(rx_data), 32'd0);
        check_eq("midreset_rx_done", 32'(rx_done), 32'd0);
        check_eq("midreset_frame_err", 32'(frame_err), 32'd0);
        check_eq("midreset_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        r_last_good   = 8'h00;
        r_prev_strobe = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(2 * OSR);
        check_eq("abort_no_strobe", 32'(n_strobes - n_before), 32'd0);
        send_frame(8'h81, 1'b1, -1, 4);
        check_eq("post_reset_data", 32'(rx_data), 32'h81);

        // 0x00 with a one-tick glitch on bit 3 at the single-sample point.
        send_frame(8'h00, 1'b1, 3, 4);
`ifdef UART_RX_MAJORITY_EN
        check_eq("glitch_data", 32'(rx_data), 32'h00);
`else
        check_eq("glitch_data", 32'(rx_data), 32'h08);
`endif

        // Randomized frames, tick rates and gaps.
        for (int f = 0; f < 30; f++) begin
            r_div = $urandom_range(1, 5);
            rd    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 9) != 0);
            rgap  = $urandom_range(0, 12);
            if (!rstop && rgap == 0) rgap = 1;
            send_frame(rd, rstop, -1, rgap);
        end

        // Every expected outcome must have been seen.
        budget = 0;
        while (r_exp_q.size() != 0 && budget < 5000) begin
            @(posedge clk);
            budget = budget + 1;
        end
        check_eq("outcomes_pending", 32'(r_exp_q.size()), 32'd0);
        check_eq("final_data", 32'(rx_data), 32'(r_last_good));
        check_eq("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
